// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding select codes
// and default field widths / md-unit latencies.
package hazard_pkg;

  // Forwarding select codes shared by all operand muxes.
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  // Default Tuse/Tnew field width.
  localparam int unsigned TW_DEF = 2;

  // Default md-unit occupancy after the instruction leaves E.
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

endpackage

// File: rtl/hazard_src_chk.sv
// Per-operand RAW checker for one D-stage source: finds the youngest matching
// producer among E and M, decides whether D must stall, and picks the D forward.
module hazard_src_chk
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned TW     = TW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [TW-1:0]     tuse,
  input  logic [REG_AW-1:0] e_wdst,
  input  logic              e_we,
  input  logic [TW-1:0]     e_tnew,
  input  logic [REG_AW-1:0] m_wdst,
  input  logic              m_we,
  input  logic [TW-1:0]     m_tnew,
  output logic              stall,
  output logic [1:0]        fwd_sel
);

  logic e_match;
  logic m_match;

  // Register 0 is hardwired and never produces a hazard.
  assign e_match = (src != '0) && e_we && (src == e_wdst);
  assign m_match = (src != '0) && m_we && (src == m_wdst);

  // Youngest matching producer decides both stall and forward; older ones are ignored.
  always_comb begin
    stall   = 1'b0;
    fwd_sel = FWD_NONE;
    if (e_match) begin
      stall = (tuse < e_tnew);
      if (e_tnew == '0) fwd_sel = FWD_E;
    end else if (m_match) begin
      stall = (tuse < m_tnew);
      if (m_tnew == '0) fwd_sel = FWD_M;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/forward controller for the 5-stage pipeline with a mult/div busy tracker.
// Optional feature: define HAZ_PERF_CNT_EN to add the saturating stall_cnt output.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned TW       = TW_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [TW-1:0]     D_tuse_rs,
  input  logic [TW-1:0]     D_tuse_rt,
  input  logic              D_md,
  input  logic [REG_AW-1:0] E_rs,
  input  logic [REG_AW-1:0] E_rt,
  input  logic [REG_AW-1:0] E_wdst,
  input  logic              E_we,
  input  logic [TW-1:0]     E_tnew,
  input  logic              E_md_start,
  input  logic              E_md_div,
  input  logic [REG_AW-1:0] M_rt,
  input  logic [REG_AW-1:0] M_wdst,
  input  logic              M_we,
  input  logic [TW-1:0]     M_tnew,
  input  logic [REG_AW-1:0] W_wdst,
  input  logic              W_we,
  output logic              stall,
  output logic              md_busy,
  output logic [1:0]        fwd_D_rs,
  output logic [1:0]        fwd_D_rt,
  output logic [1:0]        fwd_E_rs,
  output logic [1:0]        fwd_E_rt,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              fwd_M_rt
);

  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  logic          rs_stall;
  logic          rt_stall;
  logic          md_stall;
  logic [CW-1:0] cnt_q;

  hazard_src_chk #(
    .REG_AW (REG_AW),
    .TW     (TW)
  ) u_chk_rs (
    .src     (D_rs),
    .tuse    (D_tuse_rs),
    .e_wdst  (E_wdst),
    .e_we    (E_we),
    .e_tnew  (E_tnew),
    .m_wdst  (M_wdst),
    .m_we    (M_we),
    .m_tnew  (M_tnew),
    .stall   (rs_stall),
    .fwd_sel (fwd_D_rs)
  );

  hazard_src_chk #(
    .REG_AW (REG_AW),
    .TW     (TW)
  ) u_chk_rt (
    .src     (D_rt),
    .tuse    (D_tuse_rt),
    .e_wdst  (E_wdst),
    .e_we    (E_we),
    .e_tnew  (E_tnew),
    .m_wdst  (M_wdst),
    .m_we    (M_we),
    .m_tnew  (M_tnew),
    .stall   (rt_stall),
    .fwd_sel (fwd_D_rt)
  );

  // E operands forward from M (when ready) or W; E itself is never a source here.
  always_comb begin
    fwd_E_rs = FWD_NONE;
    fwd_E_rt = FWD_NONE;
    if ((E_rs != '0) && M_we && (E_rs == M_wdst)) begin
      if (M_tnew == '0) fwd_E_rs = FWD_M;
    end else if ((E_rs != '0) && W_we && (E_rs == W_wdst)) begin
      fwd_E_rs = FWD_W;
    end
    if ((E_rt != '0) && M_we && (E_rt == M_wdst)) begin
      if (M_tnew == '0) fwd_E_rt = FWD_M;
    end else if ((E_rt != '0) && W_we && (E_rt == W_wdst)) begin
      fwd_E_rt = FWD_W;
    end
  end

  assign fwd_M_rt = (M_rt != '0) && W_we && (M_rt == W_wdst);

  assign md_stall = D_md && (md_busy || E_md_start);
  assign stall    = rs_stall | rt_stall | md_stall;
  assign md_busy  = (cnt_q != '0);

  // md occupancy counter; the instruction already in E always advances (stall
  // only bubbles what enters E), so its start is never suppressed. Last start wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (E_md_start) begin
      cnt_q <= E_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (default parameters).
module tb_hazard_unit;

  logic       clk;
  logic       reset_n;
  logic [4:0] D_rs, D_rt, E_rs, E_rt, E_wdst, M_rt, M_wdst, W_wdst;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_md, E_we, E_md_start, E_md_div, M_we, W_we;
  logic       stall, md_busy, fwd_M_rt;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_md       (D_md),
    .E_rs       (E_rs),
    .E_rt       (E_rt),
    .E_wdst     (E_wdst),
    .E_we       (E_we),
    .E_tnew     (E_tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .M_rt       (M_rt),
    .M_wdst     (M_wdst),
    .M_we       (M_we),
    .M_tnew     (M_tnew),
    .W_wdst     (W_wdst),
    .W_we       (W_we),
    .stall      (stall),
    .md_busy    (md_busy),
    .fwd_D_rs   (fwd_D_rs),
    .fwd_D_rt   (fwd_D_rt),
    .fwd_E_rs   (fwd_E_rs),
    .fwd_E_rt   (fwd_E_rt),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .fwd_M_rt   (fwd_M_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; D_tuse_rs = 0; D_tuse_rt = 0; D_md = 0;
    E_rs = 0; E_rt = 0; E_wdst = 0; E_we = 0; E_tnew = 0;
    E_md_start = 0; E_md_div = 0;
    M_rt = 0; M_wdst = 0; M_we = 0; M_tnew = 0;
    W_wdst = 0; W_we = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    #1;
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_busy", {31'b0, md_busy}, 0);
    check("rst_fwd", {22'b0, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // lw $t0 in E (tnew 2), addu in D reads $t0 at tuse 1 -> stall.
    E_wdst = 8; E_we = 1; E_tnew = 2; D_rs = 8; D_tuse_rs = 1; #1;
    check("lw_e_stall", {31'b0, stall}, 1);
    check("lw_e_fwd", {30'b0, fwd_D_rs}, 0);
    // lw now in M with tnew 1: tuse 1 is not less than 1 -> no stall.
    E_wdst = 0; E_we = 0; E_tnew = 0; M_wdst = 8; M_we = 1; M_tnew = 1; #1;
    check("lw_m_tuse1", {31'b0, stall}, 0);
    // Branch consumer (tuse 0) still must wait on M tnew 1.
    D_tuse_rs = 0; #1;
    check("lw_m_tuse0", {31'b0, stall}, 1);
    // Producer ready in M: D and E both forward from M.
    M_tnew = 0; E_rs = 8; #1;
    check("lw_m_ready_stall", {31'b0, stall}, 0);
    check("fwd_D_rs_M", {30'b0, fwd_D_rs}, 2);
    check("fwd_E_rs_M", {30'b0, fwd_E_rs}, 2);

    // addu $t1 in E (tnew 1), beq in D at tuse 0 on rt.
    clear_inputs();
    E_wdst = 9; E_we = 1; E_tnew = 1; D_rt = 9; D_tuse_rt = 0; #1;
    check("beq_e_stall", {31'b0, stall}, 1);
    E_wdst = 0; E_we = 0; E_tnew = 0; M_wdst = 9; M_we = 1; M_tnew = 0; #1;
    check("beq_m_stall", {31'b0, stall}, 0);
    check("fwd_D_rt_M", {30'b0, fwd_D_rt}, 2);

    // E and M both write $t2 and are ready: E is youngest and wins.
    clear_inputs();
    E_wdst = 10; E_we = 1; M_wdst = 10; M_we = 1; D_rs = 10; D_rt = 10; #1;
    check("e_wins_rs", {30'b0, fwd_D_rs}, 1);
    check("e_wins_rt", {30'b0, fwd_D_rt}, 1);
    // Register 0 never matches, even with a slow producer.
    clear_inputs();
    E_wdst = 0; E_we = 1; E_tnew = 2; D_rs = 0; D_tuse_rs = 0; #1;
    check("r0_stall", {31'b0, stall}, 0);
    check("r0_fwd", {30'b0, fwd_D_rs}, 0);

    // Younger E (tnew 1) shadows older M (tnew 2) for tuse 1.
    clear_inputs();
    E_wdst = 13; E_we = 1; E_tnew = 1; M_wdst = 13; M_we = 1; M_tnew = 2;
    D_rs = 13; D_tuse_rs = 1; #1;
    check("older_ignored", {31'b0, stall}, 0);
    // Not-yet-written E destination disabled by we=0: falls to M, 1<2 -> stall.
    E_we = 0; #1;
    check("m_only_stall", {31'b0, stall}, 1);

    // W forwarding for E and M operands.
    clear_inputs();
    E_rt = 12; M_rt = 12; W_wdst = 12; W_we = 1; #1;
    check("fwd_E_rt_W", {30'b0, fwd_E_rt}, 3);
    check("fwd_M_rt_W", {31'b0, fwd_M_rt}, 1);
    M_wdst = 12; M_we = 1; M_tnew = 0; #1;
    check("fwd_E_rt_M_over_W", {30'b0, fwd_E_rt}, 2);
    W_we = 0; M_we = 0; #1;
    check("fwd_E_rt_none", {30'b0, fwd_E_rt}, 0);
    check("fwd_M_rt_none", {31'b0, fwd_M_rt}, 0);

    // div in E with mflo in D: stall now, then busy exactly 10 cycles.
    clear_inputs();
    E_md_start = 1; E_md_div = 1; D_md = 1; #1;
    check("div_start_stall", {31'b0, stall}, 1);
    check("div_start_busy", {31'b0, md_busy}, 0);
    step();
    E_md_start = 0; E_md_div = 0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      check($sformatf("div_busy_%0d", i), {31'b0, md_busy}, 1);
      check($sformatf("div_stall_%0d", i), {31'b0, stall}, 1);
      step();
    end
    check("div_done_busy", {31'b0, md_busy}, 0);
    check("div_done_stall", {31'b0, stall}, 0);

    // mult: busy 5 cycles.
    D_md = 0; E_md_start = 1; step(); E_md_start = 0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mult_busy_%0d", i), {31'b0, md_busy}, 1);
      step();
    end
    check("mult_done_busy", {31'b0, md_busy}, 0);

    // mult interrupted by async reset at busy cycle 2.
    E_md_start = 1; step(); E_md_start = 0;
    check("mult_rst_c1", {31'b0, md_busy}, 1);
    step();
    check("mult_rst_c2", {31'b0, md_busy}, 1);
    reset_n = 1'b0; #1;
    check("mult_rst_async", {31'b0, md_busy}, 0);
    step();
    reset_n = 1'b1; D_md = 1; #1;
    check("mfhi_after_rst", {31'b0, stall}, 0);
    step();
    check("mfhi_after_rst2", {31'b0, stall}, 0);

`ifdef HAZ_PERF_CNT_EN
    // Two stalled cycles then release: counter holds 2.
    clear_inputs();
    reset_n = 1'b0; #1; reset_n = 1'b1;
    check("perf_rst", stall_cnt, 0);
    E_wdst = 8; E_we = 1; E_tnew = 2; D_rs = 8; D_tuse_rs = 0; step();
    clear_inputs(); M_wdst = 8; M_we = 1; M_tnew = 1; D_rs = 8; step();
    clear_inputs(); step();
    check("perf_cnt", stall_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
